// File: rtl/inst_rom_ldr.sv
// Instruction ROM with a byte-serial program loader; holds the core in reset
// while a program is being written and releases it once the load is flushed.
//
// state | meaning
// IDLE  | after reset; core held, waiting for a load or a run request
// LOAD  | accepting bytes, assembling big-endian words into mem
// FLUSH | one cycle to write any zero-padded partial word
// RUN   | core released, fetches served from mem
module inst_rom_ldr #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           addr,
    output logic [31:0]           inst,
    input  logic                  ld_start_i,
    input  logic                  ld_valid_i,
    input  logic [7:0]            ld_byte_i,
    input  logic                  ld_done_i,
    output logic                  ld_ready_o,
    output logic                  core_rst_o,
    output logic [DEPTH_LOG2:0]   words_o,
    output logic                  ovf_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t              state;
    logic [DEPTH_LOG2:0] wptr;
    logic [1:0]          bcnt;
    logic [31:0]         asm_q;
    logic                ovf;
    logic [31:0]         mem [DEPTH];

    logic [31:0] next_word;
    logic [31:0] pad_word;
    logic        full;
    logic        unused_addr;

    assign next_word = {asm_q[23:0], ld_byte_i};
    assign full      = (wptr == FULL);

    // Partial word left-justified: the bytes already received keep their
    // big-endian positions and the missing low bytes read as zero.
    always_comb begin
        pad_word = asm_q;
        case (bcnt)
            2'd1:    pad_word = {asm_q[7:0], 24'h0};
            2'd2:    pad_word = {asm_q[15:0], 16'h0};
            2'd3:    pad_word = {asm_q[23:0], 8'h0};
            default: pad_word = asm_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            wptr  <= '0;
            bcnt  <= '0;
            asm_q <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ld_start_i) begin
                        state <= S_LOAD;
                        wptr  <= '0;
                        bcnt  <= '0;
                        asm_q <= '0;
                        ovf   <= 1'b0;
                    end else if (ld_done_i) begin
                        state <= S_RUN;
                    end
                end
                S_LOAD: begin
                    if (ld_valid_i) begin
                        asm_q <= next_word;
                        bcnt  <= bcnt + 2'd1;
                        if (bcnt == 2'd3) begin
                            if (full) begin
                                ovf <= 1'b1;
                            end else begin
                                mem[wptr[DEPTH_LOG2-1:0]] <= next_word;
                                wptr <= wptr + 1'b1;
                            end
                        end
                    end
                    if (ld_done_i) state <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (bcnt != 2'd0) begin
                        if (full) begin
                            ovf <= 1'b1;
                        end else begin
                            mem[wptr[DEPTH_LOG2-1:0]] <= pad_word;
                            wptr <= wptr + 1'b1;
                        end
                    end
                    bcnt  <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (ld_start_i) begin
                        state <= S_LOAD;
                        wptr  <= '0;
                        bcnt  <= '0;
                        asm_q <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ld_ready_o = (state == S_LOAD);
    assign core_rst_o = rst | (state != S_RUN);
    assign words_o    = wptr;
    assign ovf_o      = ovf;

    // Byte offset and high address bits are dropped so fetches wrap on ROM size.
    assign inst = (ce && !rst && state == S_RUN) ? mem[addr[DEPTH_LOG2+1:2]] : 32'h0;
    assign unused_addr = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};

endmodule

// File: doc/inst_rom_ldr.md
INST_ROM_LDR -- requirements
Module: inst_rom_ldr

Interface
REQ-001 Parameter DEPTH_LOG2, default 10, log2 of ROM depth in 32-bit words (DEPTH = 2^DEPTH_LOG2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ce  input  1  core instruction-fetch enable; driven by the core's rom_ce_o.
REQ-005 addr  input  32  core fetch byte address; driven by the core's rom_addr_o.
REQ-006 inst  output  32  instruction word to the core's rom_data_i.
REQ-007 ld_start_i  input  1  one-cycle pulse; begins a program load.
REQ-008 ld_valid_i  input  1  ld_byte_i carries a byte this cycle.
REQ-009 ld_byte_i  input  8  program byte, big-endian order within each word.
REQ-010 ld_done_i  input  1  one-cycle pulse; ends the load and releases the core.
REQ-011 ld_ready_o  output  1  high when load bytes are accepted.
REQ-012 core_rst_o  output  1  reset to the core; high whenever the core must not fetch.
REQ-013 words_o  output  DEPTH_LOG2+1  number of words written in the current or last load.
REQ-014 ovf_o  output  1  sticky flag: bytes arrived after the ROM was full.

Function
REQ-015 The FSM SHALL have states IDLE, LOAD, FLUSH and RUN.
REQ-016 The FSM SHALL take these transitions:
- IDLE -> LOAD on ld_start_i.
- IDLE -> RUN on ld_done_i without ld_start_i; existing contents are executed.
- LOAD -> FLUSH on ld_done_i.
- FLUSH -> RUN unconditionally after one cycle.
- RUN -> LOAD on ld_start_i.
REQ-017 Simultaneous ld_start_i and ld_done_i SHALL be resolved as follows: ld_start_i wins in IDLE and RUN; ld_start_i is ignored in LOAD and FLUSH.
REQ-018 Entering LOAD SHALL clear the write pointer, the byte count, the assembly register and ovf_o.
REQ-019 ld_ready_o SHALL equal (state==LOAD); ld_valid_i SHALL be ignored in every other state.
REQ-020 Byte assembly in LOAD: each accepted byte SHALL shift into the assembly register MSB-first, so the first byte lands in bits 31:24, and SHALL increment a 2-bit byte count.
REQ-021 On the 4th byte, the completed word SHALL be written to mem[wptr] at that same clock edge, wptr SHALL increment, and the byte count SHALL wrap to 0.
REQ-022 When wptr==DEPTH, a completed word SHALL be discarded, wptr SHALL hold, and ovf_o SHALL be set.
REQ-023 ld_valid_i together with ld_done_i in LOAD SHALL accept the byte before the transition to FLUSH.
REQ-024 In FLUSH with byte count != 0, the partial word SHALL be written with its missing low bytes zero-padded and wptr SHALL increment; the overflow rule of REQ-022 applies.
REQ-025 In FLUSH with byte count == 0, no write SHALL occur.
REQ-026 words_o SHALL equal wptr at all times.
REQ-027 inst SHALL be combinational: mem[addr[DEPTH_LOG2+1:2]] when ce==1 and state==RUN, else 32'h0.
REQ-028 addr[1:0] and address bits above DEPTH_LOG2+1 SHALL be ignored, so fetch addresses wrap modulo the ROM size.
REQ-029 core_rst_o SHALL equal rst OR (state!=RUN), combinationally; the core leaves reset in the first cycle the FSM is in RUN.
REQ-030 mem SHALL be written only by REQ-021 and REQ-024.

Reset
REQ-031 rst SHALL force: state IDLE; wptr, byte count and assembly register 0; ovf_o 0; ld_ready_o 0; core_rst_o 1; inst 0.
REQ-032 rst SHALL NOT clear mem contents.
REQ-033 rst asserted mid-LOAD SHALL abandon the load: any partial word is dropped, and words already written stay in mem.
REQ-034 rst SHALL take priority over ld_start_i and ld_done_i in the same cycle.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Load and run: start; bytes 34 02 00 20, 34 03 00 10; done -> words_o=2; core_rst_o falls 2 cycles after done; ce=1, addr=4 -> inst=32'h34030010.
- Partial flush: start; bytes AA BB; done -> mem[0]=32'hAABB0000; words_o=1.
- Overflow (DEPTH_LOG2=2): start; 20 bytes; done -> words_o=4; ovf_o=1; mem[0..3] hold the first 16 bytes.
- Byte with done, reload from RUN: ld_valid_i with ld_done_i accepted; a later ld_start_i in RUN clears ovf_o, words_o=0, and raises core_rst_o the next cycle.
- Reset mid-load: 6 bytes then rst -> state IDLE; words_o=0; mem[0] retained; done -> RUN executes old mem[1].
- Fetch gating: ce=0 or state!=RUN -> inst=0; addr=32'h0000_1004 with DEPTH_LOG2=10 -> reads mem[1].
